onehot_encoder_32_5: RTL and testbench

- Inverse of the register-file 5-to-32 one-hot decoder.
- Accepts a 32-bit request/select mask, then serially emits the 5-bit index of every set bit, one index per output beat.
- Valid/ready handshake on both sides.
- Used for register-write-enable readback and self-check, and for turning pending-request masks into indices for the issue/debug logic.

---
 rtl/onehot_encoder_32_5.sv | 94 +++++++++
 tb/tb_onehot_encoder_32_5.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_encoder_32_5.sv
// Serialises a select/request mask into a burst of set-bit indices (inverse of the 5-to-32 decoder).
// One mask is held at a time; in_ready stays low until its final beat has been accepted.
module onehot_encoder_32_5 #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned IDX_W     = 5,
   parameter bit          LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_mask,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_index,
   output logic             out_last,
   output logic             out_empty,
   output logic [IDX_W:0]   out_count,
   output logic             out_onehot
);

   typedef enum logic [0:0] {StIdle, StEmit} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] pending_q;
   logic [IDX_W:0]   in_count;
   logic             at_most_one;

   function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] m);
      logic [IDX_W:0] c;
      c = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         c = c + {{IDX_W{1'b0}}, m[i]};
      end
      return c;
   endfunction

   assign in_count = popcount(in_mask);

   // Priority pick over pending: the last match in the scan direction wins.
   always_comb begin
      out_index = '0;
      if (LSB_FIRST) begin
         for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (pending_q[i]) out_index = IDX_W'(i);
         end
      end else begin
         for (int i = 0; i < int'(WIDTH); i++) begin
            if (pending_q[i]) out_index = IDX_W'(i);
         end
      end
   end

   assign at_most_one = (pending_q & (pending_q - WIDTH'(1))) == '0;
   assign out_valid   = (state_q == StEmit);
   assign in_ready    = (state_q == StIdle);
   assign out_last    = out_valid && at_most_one;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         pending_q  <= '0;
         out_count  <= '0;
         out_onehot <= 1'b0;
         out_empty  <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (in_valid) begin
                  pending_q  <= in_mask;
                  out_count  <= in_count;
                  out_onehot <= (in_count == (IDX_W+1)'(1));
                  out_empty  <= (in_mask == '0);
                  state_q    <= StEmit;
               end
            end
            StEmit: begin
               if (out_ready) begin
                  // Harmless for an empty mask: bit 0 is already clear.
                  pending_q[out_index] <= 1'b0;
                  if (out_last) begin
                     state_q    <= StIdle;
                     out_count  <= '0;
                     out_onehot <= 1'b0;
                     out_empty  <= 1'b0;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_onehot_encoder_32_5.sv
// Directed and randomised round-trip checks of onehot_encoder_32_5 in both scan orders.
module tb_onehot_encoder_32_5;

   logic        clk;
   logic        rst_n;

   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [31:0] a_in_mask;
   logic [4:0]  a_out_index;
   logic        a_out_last, a_out_empty, a_out_onehot;
   logic [5:0]  a_out_count;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [31:0] b_in_mask;
   logic [4:0]  b_out_index;
   logic        b_out_last, b_out_empty, b_out_onehot;
   logic [5:0]  b_out_count;

   int n_cmp = 0;
   int n_err = 0;

   onehot_encoder_32_5 #(.WIDTH(32), .IDX_W(5), .LSB_FIRST(1'b1)) u_lsb (
      .clk(clk), .rst_n(rst_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mask(a_in_mask),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_index(a_out_index),
      .out_last(a_out_last), .out_empty(a_out_empty), .out_count(a_out_count),
      .out_onehot(a_out_onehot)
   );

   onehot_encoder_32_5 #(.WIDTH(32), .IDX_W(5), .LSB_FIRST(1'b0)) u_msb (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mask(b_in_mask),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_index(b_out_index),
      .out_last(b_out_last), .out_empty(b_out_empty), .out_count(b_out_count),
      .out_onehot(b_out_onehot)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_send(input logic [31:0] m);
      a_in_mask  = m;
      a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      a_in_mask  = '0;
   endtask

   task automatic b_send(input logic [31:0] m);
      b_in_mask  = m;
      b_in_valid = 1'b1;
      tick();
      b_in_valid = 1'b0;
      b_in_mask  = '0;
   endtask

   function automatic int low_bit(input logic [31:0] m);
      for (int i = 0; i < 32; i++) begin
         if (m[i]) return i;
      end
      return 0;
   endfunction

   logic [31:0] m, acc, rem;
   int          pc, beats;
   logic        done;

   initial begin
      rst_n = 1'b0;
      a_in_valid = 1'b0; a_in_mask = '0; a_out_ready = 1'b0;
      b_in_valid = 1'b0; b_in_mask = '0; b_out_ready = 1'b0;

      // Reset and idle
      #12;
      check("rst_valid", a_out_valid, 0);
      check("rst_last", a_out_last, 0);
      check("rst_count", a_out_count, 0);
      check("rst_onehot", a_out_onehot, 0);
      check("rst_empty", a_out_empty, 0);
      check("rst_index", a_out_index, 0);
      tick();
      rst_n = 1'b1;
      tick();
      check("idle_in_ready", a_in_ready, 1);
      check("idle_out_valid", a_out_valid, 0);

      // One-hot mask
      a_out_ready = 1'b1;
      a_send(32'h0000_0100);
      check("oh_valid", a_out_valid, 1);
      check("oh_in_ready", a_in_ready, 0);
      check("oh_index", a_out_index, 8);
      check("oh_last", a_out_last, 1);
      check("oh_onehot", a_out_onehot, 1);
      check("oh_count", a_out_count, 1);
      check("oh_empty", a_out_empty, 0);
      tick();
      check("oh_in_ready_back", a_in_ready, 1);
      check("oh_valid_done", a_out_valid, 0);
      check("oh_count_clr", a_out_count, 0);
      check("oh_onehot_clr", a_out_onehot, 0);

      // Multi-bit with back-pressure; in_valid must be ignored during the burst
      a_send(32'h8000_0011);
      a_out_ready = 1'b1;
      check("mb_idx0", a_out_index, 0);
      check("mb_last0", a_out_last, 0);
      check("mb_count", a_out_count, 3);
      check("mb_onehot", a_out_onehot, 0);
      tick();
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_mask = 32'hFFFF_FFFF;
      check("mb_idx4_a", a_out_index, 4);
      tick();
      check("mb_idx4_stall", a_out_index, 4);
      check("mb_last_stall", a_out_last, 0);
      check("mb_count_stall", a_out_count, 3);
      tick();
      a_out_ready = 1'b1;
      a_in_valid = 1'b0; a_in_mask = '0;
      check("mb_idx4_b", a_out_index, 4);
      check("mb_valid_stall", a_out_valid, 1);
      tick();
      check("mb_idx31", a_out_index, 31);
      check("mb_last31", a_out_last, 1);
      check("mb_count_end", a_out_count, 3);
      tick();
      check("mb_done", a_out_valid, 0);
      check("mb_in_ready", a_in_ready, 1);

      // Zero mask
      a_send(32'h0);
      check("z_valid", a_out_valid, 1);
      check("z_empty", a_out_empty, 1);
      check("z_index", a_out_index, 0);
      check("z_last", a_out_last, 1);
      check("z_count", a_out_count, 0);
      check("z_onehot", a_out_onehot, 0);
      tick();
      check("z_done", a_out_valid, 0);
      check("z_empty_clr", a_out_empty, 0);

      // All-ones mask
      a_send(32'hFFFF_FFFF);
      for (int i = 0; i < 32; i++) begin
         check("ao_valid", a_out_valid, 1);
         check("ao_index", a_out_index, i);
         check("ao_last", a_out_last, (i == 31));
         check("ao_count", a_out_count, 6'b100000);
         tick();
      end
      check("ao_done", a_out_valid, 0);

      // MSB-first scan with reset mid-burst
      b_out_ready = 1'b1;
      b_send(32'h0000_00F0);
      check("msb_idx7", b_out_index, 7);
      check("msb_count", b_out_count, 4);
      tick();
      check("msb_idx6", b_out_index, 6);
      tick();
      check("msb_idx5", b_out_index, 5);
      #2 rst_n = 1'b0;
      #1;
      check("mr_valid", b_out_valid, 0);
      check("mr_index", b_out_index, 0);
      check("mr_last", b_out_last, 0);
      check("mr_count", b_out_count, 0);
      check("mr_onehot", b_out_onehot, 0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("mr_no_beat", b_out_valid, 0);
         check("mr_in_ready", b_in_ready, 1);
      end
      b_send(32'h0000_0002);
      check("msb2_index", b_out_index, 1);
      check("msb2_last", b_out_last, 1);
      check("msb2_onehot", b_out_onehot, 1);
      check("msb2_count", b_out_count, 1);
      tick();
      check("msb2_done", b_out_valid, 0);

      // Random round trip, LSB-first instance, random back-pressure
      for (int n = 0; n < 1000; n++) begin
         case (n % 4)
            0: m = $urandom;
            1: m = $urandom & $urandom & $urandom;
            2: m = ((n % 8) == 2) ? 32'h0 : (32'h1 << $urandom_range(31, 0));
            default: m = $urandom | $urandom;
         endcase
         pc = $countones(m);
         a_send(m);
         acc = '0; rem = m; beats = 0; done = 1'b0;
         for (int c = 0; c < 400 && !done; c++) begin
            a_out_ready = ($urandom_range(3, 0) != 0);
            if (a_out_valid && a_out_ready) begin
               check("rt_index", a_out_index, low_bit(rem));
               check("rt_last", a_out_last, ($countones(rem) <= 1));
               check("rt_count", a_out_count, pc);
               check("rt_empty", a_out_empty, (m == 32'h0));
               if (!a_out_empty) begin
                  check("rt_repeat", acc[a_out_index], 0);
                  acc[a_out_index] = 1'b1;
                  rem[a_out_index] = 1'b0;
               end
               beats++;
               if (a_out_last) done = 1'b1;
            end
            tick();
         end
         check("rt_done", done, 1);
         check("rt_mask", acc, m);
         check("rt_beats", beats, (pc > 1) ? pc : 1);
         check("rt_in_ready", a_in_ready, 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
